// File: rtl/lcd_id_pkg.sv
// Shared panel-ID definitions: reader state encoding, the five known panel IDs
// and the strap-code decode also used by the pixel-clock divider.
package lcd_id_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RELEASE = 3'd1,
        SETTLE  = 3'd2,
        SAMPLE  = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5,
        FAIL    = 3'd6
    } lcd_state_t;

    localparam logic [15:0] ID_CODE_000 = 16'h4342;
    localparam logic [15:0] ID_CODE_001 = 16'h7084;
    localparam logic [15:0] ID_CODE_010 = 16'h7016;
    localparam logic [15:0] ID_CODE_100 = 16'h4384;
    localparam logic [15:0] ID_CODE_101 = 16'h1018;

    // Code is {M2,M1,M0}; anything not listed is an unsupported panel.
    function automatic logic id_known(input logic [2:0] code);
        case (code)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: id_known = 1'b1;
            default:                                id_known = 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] decode_id(input logic [2:0] code);
        case (code)
            3'b000:  decode_id = ID_CODE_000;
            3'b001:  decode_id = ID_CODE_001;
            3'b010:  decode_id = ID_CODE_010;
            3'b100:  decode_id = ID_CODE_100;
            3'b101:  decode_id = ID_CODE_101;
            default: decode_id = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/lcd_id_sync.sv
// Two-flop synchronizer for asynchronous strap inputs; 2-cycle latency,
// no flow control (free-running sampler).
module lcd_id_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lcd_id_reader.sv
// Reads the panel strap code off the released RGB bus and decodes the panel ID.
// Result after 1+SETTLE_CYCLES+SAMPLES+1 cycles per attempt; rd_req honoured only when idle.
module lcd_id_reader
    import lcd_id_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1000,
    parameter int SAMPLES       = 4,
    parameter int MAX_RETRY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [23:0] lcd_rgb_in,
    output logic        lcd_rgb_oe,
    output logic [15:0] lcd_id,
    output logic        id_valid,
    output logic        id_err,
    output logic        busy
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam int RW      = $clog2(MAX_RETRY + 1) + 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

    lcd_state_t    state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry;
    logic [2:0]    ref_code;
    logic          mismatch;
    logic [2:0]    code_sync;

    // Strap bits live on the MSB of each colour channel: M2=B7, M1=G7, M0=R7.
    lcd_id_sync #(.WIDTH(3)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({lcd_rgb_in[7], lcd_rgb_in[15], lcd_rgb_in[23]}),
        .q   (code_sync)
    );

    logic unused_rgb;
    assign unused_rgb = ^{lcd_rgb_in[22:16], lcd_rgb_in[14:8], lcd_rgb_in[6:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RELEASE;
            cnt        <= '0;
            retry      <= '0;
            ref_code   <= '0;
            mismatch   <= 1'b0;
            lcd_rgb_oe <= 1'b0;
            lcd_id     <= '0;
            id_valid   <= 1'b0;
            id_err     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                RELEASE: begin
                    cnt   <= '0;
                    retry <= '0;
                    busy  <= 1'b1;
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt      <= '0;
                        mismatch <= 1'b0;
                        state    <= SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (cnt == '0) begin
                        ref_code <= code_sync;
                    end else if (code_sync != ref_code) begin
                        mismatch <= 1'b1;
                    end
                    if (cnt == SAMPLE_LAST) begin
                        cnt   <= '0;
                        state <= CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch && (retry < RETRY_MAX)) begin
                        retry <= retry + 1'b1;
                        state <= SETTLE;
                    end else if (mismatch || !id_known(ref_code)) begin
                        lcd_id   <= '0;
                        id_valid <= 1'b0;
                        id_err   <= 1'b1;
                        busy     <= 1'b0;
                        state    <= FAIL;
                    end else begin
                        lcd_id     <= decode_id(ref_code);
                        id_valid   <= 1'b1;
                        id_err     <= 1'b0;
                        lcd_rgb_oe <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE, FAIL: begin
                    if (rd_req) begin
                        id_valid   <= 1'b0;
                        id_err     <= 1'b0;
                        lcd_rgb_oe <= 1'b0;
                        busy       <= 1'b1;
                        state      <= RELEASE;
                    end
                end
                default: begin
                    // IDLE or an illegal encoding: restart a clean read.
                    cnt        <= '0;
                    mismatch   <= 1'b0;
                    id_valid   <= 1'b0;
                    id_err     <= 1'b0;
                    lcd_rgb_oe <= 1'b0;
                    busy       <= 1'b1;
                    state      <= RELEASE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_id_reader.sv
// Directed self-checking bench for lcd_id_reader (SETTLE_CYCLES=8, SAMPLES=4, MAX_RETRY=2).
module tb_lcd_id_reader;

    logic        clk;
    logic        rst;
    logic        rd_req;
    logic [23:0] lcd_rgb_in;
    logic        lcd_rgb_oe;
    logic [15:0] lcd_id;
    logic        id_valid;
    logic        id_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    lcd_id_reader #(
        .SETTLE_CYCLES (8),
        .SAMPLES       (4),
        .MAX_RETRY     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .lcd_rgb_in (lcd_rgb_in),
        .lcd_rgb_oe (lcd_rgb_oe),
        .lcd_id     (lcd_id),
        .id_valid   (id_valid),
        .id_err     (id_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mk_rgb(input logic [2:0] c);
        logic [23:0] v;
        v     = 24'h5AA53C & ~24'h808080;
        v[7]  = c[2];
        v[15] = c[1];
        v[23] = c[0];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Clocks a read from RELEASE; toggles M0 before edges 1..tog_until, pulses
    // rd_req before edge req_at. cyc = edge where id_valid/id_err first rose, 0 on timeout.
    task automatic run_read(input int tog_until, input int req_at, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            if (i <= tog_until) lcd_rgb_in[23] = ~lcd_rgb_in[23];
            rd_req = (i == req_at);
            step();
            if (id_valid || id_err) begin
                cyc = i;
                break;
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic do_reset(input logic [2:0] code);
        lcd_rgb_in = mk_rgb(code);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic issue_req();
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        do_reset(3'b001);
        checks++;
        if ({lcd_id, id_valid, id_err, lcd_rgb_oe, busy} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got id=%h v=%b e=%b oe=%b busy=%b, want all zero",
                     lcd_id, id_valid, id_err, lcd_rgb_oe, busy);
        end
        run_read(0, 0, cyc);
        checks++;
        if (cyc !== 14) begin
            errors++;
            $display("FAIL first_read_latency: got %0d, want 14", cyc);
        end
        checks++;
        if (lcd_id !== 16'h7084) begin
            errors++;
            $display("FAIL first_read_id: got %h, want 7084", lcd_id);
        end
        checks++;
        if ({lcd_rgb_oe, id_err, busy} !== 3'b100) begin
            errors++;
            $display("FAIL done_flags: got oe=%b e=%b busy=%b, want oe=1 e=0 busy=0",
                     lcd_rgb_oe, id_err, busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_reset(3'b000);
        run_read(0, 0, cyc);
        checks++;
        if (cyc !== 14 || lcd_id !== 16'h4342) begin
            errors++;
            $display("FAIL code000: got cyc=%0d id=%h, want cyc=14 id=4342", cyc, lcd_id);
        end
        lcd_rgb_in = mk_rgb(3'b101);
        step();
        step();
        checks++;
        if (lcd_id !== 16'h4342 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: got id=%h v=%b, want id=4342 v=1", lcd_id, id_valid);
        end
        issue_req();
        checks++;
        if ({id_valid, id_err, lcd_rgb_oe, busy} !== 4'b0001 || lcd_id !== 16'h4342) begin
            errors++;
            $display("FAIL rereq_release: got v=%b e=%b oe=%b busy=%b id=%h, want 0 0 0 1 id=4342",
                     id_valid, id_err, lcd_rgb_oe, busy, lcd_id);
        end
        run_read(0, 0, cyc);
        checks++;
        if (cyc !== 14 || lcd_id !== 16'h1018) begin
            errors++;
            $display("FAIL code101: got cyc=%0d id=%h, want cyc=14 id=1018", cyc, lcd_id);
        end
    endtask

    task automatic test_unknown_code();
        int cyc;
        lcd_rgb_in = mk_rgb(3'b011);
        issue_req();
        run_read(0, 0, cyc);
        checks++;
        if (cyc !== 14 || id_err !== 1'b1 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL unknown_code: got cyc=%0d e=%b v=%b, want cyc=14 e=1 v=0", cyc, id_err, id_valid);
        end
        checks++;
        if (lcd_id !== 16'h0000 || lcd_rgb_oe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fail_outputs: got id=%h oe=%b busy=%b, want id=0000 oe=0 busy=0",
                     lcd_id, lcd_rgb_oe, busy);
        end
    endtask

    task automatic test_retry_fail();
        int cyc;
        lcd_rgb_in = mk_rgb(3'b010);
        issue_req();
        checks++;
        if (id_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: got e=%b busy=%b, want e=0 busy=1", id_err, busy);
        end
        run_read(1000, 0, cyc);
        // 1 release cycle + 3 attempts of (8 settle + 4 sample + 1 check)
        checks++;
        if (cyc !== 40 || id_err !== 1'b1 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL retry_exhaust: got cyc=%0d e=%b v=%b, want cyc=40 e=1 v=0", cyc, id_err, id_valid);
        end
    endtask

    task automatic test_retry_recover();
        int cyc;
        lcd_rgb_in = mk_rgb(3'b100);
        issue_req();
        run_read(16, 0, cyc);
        checks++;
        if (cyc !== 27 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL retry_once: got cyc=%0d v=%b, want cyc=27 v=1", cyc, id_valid);
        end
        checks++;
        if (lcd_id !== 16'h4384) begin
            errors++;
            $display("FAIL retry_id: got %h, want 4384", lcd_id);
        end
    endtask

    task automatic test_rst_mid_read();
        int cyc;
        lcd_rgb_in = mk_rgb(3'b101);
        issue_req();
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (busy !== 1'b1 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL in_sample: got busy=%b v=%b, want busy=1 v=0", busy, id_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({lcd_id, id_valid, id_err, lcd_rgb_oe, busy} !== 20'h0) begin
            errors++;
            $display("FAIL abort_outputs: got id=%h v=%b e=%b oe=%b busy=%b, want all zero",
                     lcd_id, id_valid, id_err, lcd_rgb_oe, busy);
        end
        run_read(0, 5, cyc);
        checks++;
        if (cyc !== 14 || lcd_id !== 16'h1018) begin
            errors++;
            $display("FAIL busy_req_ignored: got cyc=%0d id=%h, want cyc=14 id=1018", cyc, lcd_id);
        end
        step();
        step();
        checks++;
        if (id_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_queued_req: got v=%b busy=%b, want v=1 busy=0", id_valid, busy);
        end
    endtask

    initial begin
        rst        = 1'b1;
        rd_req     = 1'b0;
        lcd_rgb_in = mk_rgb(3'b001);
        test_reset();
        test_back_to_back();
        test_unknown_code();
        test_retry_fail();
        test_retry_recover();
        test_rst_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
